// File: rtl/lcd_stream_arbiter.sv
// Round-robin, burst-locked arbiter merging up to four 16-bit LCD producer streams into one.
// One idle cycle to grant, then combinational pass-through; out_rdy backpressure goes straight to the owner.
module lcd_stream_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int MAX_BURST   = 64,
  parameter int STALL_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     src_vld,
  input  logic [16*NUM_SRC-1:0]  src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_rdy,
  output logic                   out_vld,
  output logic [15:0]            out_data,
  output logic [1:0]             out_src,
  input  logic                   out_rdy,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [8:0] BURST_END = 9'(MAX_BURST - 1);
  localparam logic [7:0] STALL_END = 8'(STALL_LIMIT - 1);

  state_t      state;
  logic [1:0]  owner;
  logic [1:0]  last_winner;
  logic [8:0]  beat_cnt;
  logic [7:0]  stall_cnt;

  logic        own_vld;
  logic        own_last;
  logic [15:0] own_data;
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic        active;
  logic        hs;
  logic        stall_expire;
  logic        release_now;

  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_data = 16'h0000;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        own_vld  = src_vld[i];
        own_last = src_last[i];
        own_data = src_data[16*i +: 16];
      end
    end
  end

  // Scan from the source after the previous winner, wrapping, so source 0 wins first out of reset.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (int'(last_winner) + k) % NUM_SRC;
      if (!pick_vld && src_vld[idx]) begin
        pick_vld = 1'b1;
        pick_idx = 2'(idx);
      end
    end
  end

  // Outputs are gated by rst_n so a beat in flight during reset is never acknowledged.
  assign active   = (state == GRANT) && rst_n;
  assign out_vld  = active && own_vld;
  assign out_data = out_vld ? own_data : 16'h0000;
  assign out_src  = active ? owner : 2'd0;
  assign src_rdy  = active ? (grant & {NUM_SRC{out_rdy}}) : '0;
  assign busy     = (state == GRANT);

  assign hs = out_vld && out_rdy;
  // A source raising vld exactly as the limit expires still loses the grant after this beat.
  assign stall_expire = (stall_cnt == STALL_END) && (!own_vld || (stall_cnt != 8'd0));
  assign release_now  = (hs && (own_last || (beat_cnt == BURST_END))) || stall_expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= 2'd0;
      last_winner <= 2'(NUM_SRC - 1);
      beat_cnt    <= 9'd0;
      stall_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= GRANT;
            grant     <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx;
            owner     <= pick_idx;
            beat_cnt  <= 9'd0;
            stall_cnt <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state       <= IDLE;
            grant       <= '0;
            last_winner <= owner;
            beat_cnt    <= 9'd0;
            stall_cnt   <= 8'd0;
          end else begin
            if (hs) beat_cnt <= beat_cnt + 9'd1;
            stall_cnt <= own_vld ? 8'd0 : stall_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_stream_arbiter.sv
// Directed bench for lcd_stream_arbiter: vector table plus sequences for burst limit, stall, backpressure, reset.
module tb_lcd_stream_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  src_vld;
  logic [31:0] src_data;
  logic [1:0]  src_last;
  logic [1:0]  src_rdy;
  logic        out_vld;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_rdy;
  logic [1:0]  grant;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  lcd_stream_arbiter #(.NUM_SRC(2), .MAX_BURST(4), .STALL_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_data(src_data),
    .src_last(src_last), .src_rdy(src_rdy), .out_vld(out_vld),
    .out_data(out_data), .out_src(out_src), .out_rdy(out_rdy),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  last;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  es;
    logic [1:0]  erdy;
    logic [1:0]  eg;
    logic        eb;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] vld, logic [15:0] d0, logic [15:0] d1,
                              logic [1:0] last, logic rdy, logic ev, logic [15:0] ed,
                              logic [1:0] es, logic [1:0] erdy, logic [1:0] eg, logic eb);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d0 = d0; v.d1 = d1; v.last = last; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.es = es; v.erdy = erdy; v.eg = eg; v.eb = eb;
    return v;
  endfunction

  // Cycle spent in IDLE: nothing visible downstream.
  function automatic vec_t vi(logic [1:0] vld, logic [15:0] d0, logic [15:0] d1,
                              logic [1:0] last, logic rdy);
    return mk(1'b1, vld, d0, d1, last, rdy, 1'b0, 16'h0, 2'd0, 2'b00, 2'b00, 1'b0);
  endfunction

  // Cycle granted to source g: owner's vld/data pass through, rdy only to the owner.
  function automatic vec_t vg(logic [1:0] vld, logic [15:0] d0, logic [15:0] d1,
                              logic [1:0] last, logic rdy, int g);
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  oh;
    ev = vld[g];
    ed = ev ? ((g == 1) ? d1 : d0) : 16'h0;
    oh = (g == 1) ? 2'b10 : 2'b01;
    return mk(1'b1, vld, d0, d1, last, rdy, ev, ed, 2'(g), rdy ? oh : 2'b00, oh, 1'b1);
  endfunction

  task automatic chk(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", name, field, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    rst_n    = v.rst;
    src_vld  = v.vld;
    src_data = {v.d1, v.d0};
    src_last = v.last;
    out_rdy  = v.rdy;
    #4;
    chk(name, "out_vld",  {15'd0, out_vld}, {15'd0, v.ev});
    chk(name, "out_data", out_data, v.ed);
    chk(name, "out_src",  {14'd0, out_src}, {14'd0, v.es});
    chk(name, "src_rdy",  {14'd0, src_rdy}, {14'd0, v.erdy});
    chk(name, "grant",    {14'd0, grant},   {14'd0, v.eg});
    chk(name, "busy",     {15'd0, busy},    {15'd0, v.eb});
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; src_vld = 2'b00; src_data = 32'h0; src_last = 2'b00; out_rdy = 1'b1;
    @(posedge clk);
    #1;

    // Single burst from source 0, then round-robin alternation with 2-beat bursts.
    tbl.push_back(mk(1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 16'h1111, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 16'h1111, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h1111, 2'd0, 2'b01, 2'b01, 1'b1));
    tbl.push_back(mk(1'b1, 2'b01, 16'h2222, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h2222, 2'd0, 2'b01, 2'b01, 1'b1));
    tbl.push_back(mk(1'b1, 2'b01, 16'h3333, 16'h0000, 2'b01, 1'b1, 1'b1, 16'h3333, 2'd0, 2'b01, 2'b01, 1'b1));
    tbl.push_back(mk(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA001, 16'hB001, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA001, 16'hB001, 2'b00, 1'b1, 1'b1, 16'hB001, 2'd1, 2'b10, 2'b10, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA001, 16'hB002, 2'b10, 1'b1, 1'b1, 16'hB002, 2'd1, 2'b10, 2'b10, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA001, 16'hB003, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA001, 16'hB003, 2'b00, 1'b1, 1'b1, 16'hA001, 2'd0, 2'b01, 2'b01, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA002, 16'hB003, 2'b01, 1'b1, 1'b1, 16'hA002, 2'd0, 2'b01, 2'b01, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA003, 16'hB003, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA003, 16'hB003, 2'b00, 1'b1, 1'b1, 16'hB003, 2'd1, 2'b10, 2'b10, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, 16'hA003, 16'hB004, 2'b10, 1'b1, 1'b1, 16'hB004, 2'd1, 2'b10, 2'b10, 1'b1));
    tbl.push_back(mk(1'b1, 2'b01, 16'hA003, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 16'hA003, 16'h0000, 2'b01, 1'b1, 1'b1, 16'hA003, 2'd0, 2'b01, 2'b01, 1'b1));
    tbl.push_back(mk(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b00, 1'b0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // Burst limit: source 1 cut after 4 beats, source 0 served, source 1 resumes at beat 5.
    apply(vi(2'b11, 16'hC000, 16'h5001, 2'b00, 1'b1), "burst_arb");
    for (int k = 1; k <= 4; k++)
      apply(vg(2'b11, 16'hC000, 16'(16'h5000 + k), 2'b00, 1'b1, 1), $sformatf("burst_b%0d", k));
    apply(vi(2'b11, 16'hC000, 16'h5005, 2'b00, 1'b1), "burst_bubble");
    apply(vg(2'b11, 16'hC000, 16'h5005, 2'b01, 1'b1, 0), "burst_src0");
    apply(vi(2'b10, 16'h0000, 16'h5005, 2'b00, 1'b1), "burst_rearb");
    apply(vg(2'b10, 16'h0000, 16'h5005, 2'b00, 1'b1, 1), "burst_b5");
    apply(vg(2'b10, 16'h0000, 16'h5006, 2'b10, 1'b1, 1), "burst_b6");
    apply(vi(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1), "burst_end");

    // Stall: source 0 sends one beat then goes quiet; grant lasts exactly 16 low cycles.
    apply(vi(2'b01, 16'hD001, 16'h0000, 2'b00, 1'b1), "stall_arb");
    apply(vg(2'b01, 16'hD001, 16'h0000, 2'b00, 1'b1, 0), "stall_beat");
    for (int k = 0; k < 16; k++)
      apply(vg(2'b10, 16'h0000, 16'hE001, 2'b00, 1'b1, 0), $sformatf("stall_low%0d", k));
    apply(vi(2'b10, 16'h0000, 16'hE001, 2'b00, 1'b1), "stall_revoked");
    apply(vg(2'b10, 16'h0000, 16'hE001, 2'b10, 1'b1, 1), "stall_src1");
    apply(vi(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1), "stall_end");

    // Backpressure: 50 cycles of out_rdy low hold the grant without timing out.
    apply(vi(2'b01, 16'hF00D, 16'h0000, 2'b00, 1'b1), "bp_arb");
    for (int k = 0; k < 50; k++)
      apply(vg(2'b01, 16'hF00D, 16'h0000, 2'b00, 1'b0, 0), $sformatf("bp_hold%0d", k));
    apply(vg(2'b01, 16'hF00D, 16'h0000, 2'b00, 1'b1, 0), "bp_xfer");
    apply(vg(2'b01, 16'hF00E, 16'h0000, 2'b01, 1'b1, 0), "bp_last");
    apply(vi(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1), "bp_end");

    // Reset during beat 2 of a source-1 burst; afterwards source 0 must win first.
    apply(vi(2'b10, 16'h0000, 16'h7001, 2'b00, 1'b1), "rst_arb");
    apply(vg(2'b10, 16'h0000, 16'h7001, 2'b00, 1'b1, 1), "rst_b1");
    apply(mk(1'b0, 2'b10, 16'h0000, 16'h7002, 2'b00, 1'b1, 1'b0, 16'h0000, 2'd0, 2'b00, 2'b10, 1'b1), "rst_mid");
    apply(vi(2'b11, 16'h8001, 16'h7002, 2'b00, 1'b1), "rst_after");
    apply(vg(2'b11, 16'h8001, 16'h7002, 2'b01, 1'b1, 0), "rst_src0_first");
    apply(vi(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1), "rst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
